// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer for the 16-bit CPU: owns PC and IR and steps each
// instruction through FETCH, DECODE, EXECUTE and WRITEBACK.
module cpu_sequencer #(
  parameter logic [15:0] PC_RESET = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [15:0] instruction,
  input  logic [15:0] alu_res,
  input  logic        alu_carry,
  input  logic        alu_zero,
  output logic [15:0] pc,
  output logic [2:0]  rega,
  output logic [2:0]  regb,
  output logic [2:0]  wreg,
  output logic [3:0]  alu_code,
  output logic        write_en,
  output logic        busy,
  output logic        halted,
  output logic        illegal,
  output logic        flag_z,
  output logic        flag_c
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [6:0] OP_JMP  = 7'h10;
  localparam logic [6:0] OP_BZ   = 7'h11;
  localparam logic [6:0] OP_HALT = 7'h7F;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic        flag_z_q, flag_z_d;
  logic        flag_c_q, flag_c_d;
  logic        write_en_q, busy_q, halted_q, illegal_q;
  logic [6:0]  opcode_s;
  logic [15:0] branch_off_s;
  logic        unused_s;

  function automatic logic is_alu_op(input logic [6:0] op);
    return (op[6:3] == 4'b0000);
  endfunction

  function automatic logic is_illegal_op(input logic [6:0] op);
    return !is_alu_op(op) && (op != OP_JMP) && (op != OP_BZ) && (op != OP_HALT);
  endfunction

  assign opcode_s     = ir_q[15:9];
  assign branch_off_s = {{7{ir_q[8]}}, ir_q[8:0]};
  // ALU result is observed by the register file directly, never stored here.
  assign unused_s     = ^alu_res;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    flag_z_d = flag_z_q;
    flag_c_d = flag_c_q;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
        else     state_d = S_IDLE;
      end
      S_FETCH: begin
        ir_d    = instruction;
        state_d = S_DECODE;
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (is_alu_op(opcode_s)) begin
          flag_z_d = alu_zero;
          flag_c_d = alu_carry;
        end else begin
          flag_z_d = flag_z_q;
        end
        state_d = S_WB;
      end
      S_WB: begin
        // HALT keeps pc pointing at itself; everything else resolves the next address here.
        if (opcode_s == OP_HALT)                 pc_d = pc_q;
        else if (opcode_s == OP_JMP)             pc_d = {7'b0000000, ir_q[8:0]};
        else if ((opcode_s == OP_BZ) && flag_z_q) pc_d = pc_q + branch_off_s;
        else                                     pc_d = pc_q + 16'd1;
        if (opcode_s == OP_HALT) state_d = S_HALT;
        else if (run)            state_d = S_FETCH;
        else                     state_d = S_IDLE;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // State, architectural registers and outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= PC_RESET;
      ir_q       <= 16'h0000;
      flag_z_q   <= 1'b0;
      flag_c_q   <= 1'b0;
      write_en_q <= 1'b0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      flag_z_q   <= flag_z_d;
      flag_c_q   <= flag_c_d;
      write_en_q <= (state_d == S_WB) && is_alu_op(ir_d[15:9]);
      illegal_q  <= (state_d == S_WB) && is_illegal_op(ir_d[15:9]);
      busy_q     <= (state_d != S_IDLE) && (state_d != S_HALT);
      halted_q   <= (state_d == S_HALT);
    end
  end

  assign pc       = pc_q;
  assign rega     = ir_q[5:3];
  assign regb     = ir_q[2:0];
  assign wreg     = ir_q[8:6];
  assign alu_code = {1'b0, ir_q[11:9]};
  assign write_en = write_en_q;
  assign busy     = busy_q;
  assign halted   = halted_q;
  assign illegal  = illegal_q;
  assign flag_z   = flag_z_q;
  assign flag_c   = flag_c_q;

endmodule
